// File: rtl/gated_bus_n.sv
// rtl/gated_bus_n.sv - N-source priority bus driver with registered copy, conflict detection and optional keeper.
// Optional bus-keeper selected by defining GATED_BUS_HOLD_EN.
module gated_bus_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [N-1:0]           gate,
  input  logic [N*WIDTH-1:0]     din,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus_q,
  output logic                   conflict,
  output logic [WIDTH-1:0]       bus_r,
  output logic [$clog2(N)-1:0]   drv_r,
  output logic                   valid_r,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] win;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] idle_val;
  logic             any;

  // Scan from the top down so the lowest set gate index is the last one written.
  always_comb begin
    win = '0;
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gate[i]) begin
        win = IDX_W'(i);
        sel = din[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any = |gate;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign conflict = |(gate & (gate - N'(1)));

`ifdef GATED_BUS_HOLD_EN
  logic [WIDTH-1:0] keeper;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keeper <= '0;
    end else if (any) begin
      keeper <= sel;
    end
  end

  assign idle_val = keeper;
`else
  assign idle_val = '0;
`endif

  assign bus_q = any ? sel : idle_val;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus_r   <= '0;
      drv_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      bus_r   <= bus_q;
      valid_r <= any;
      if (any) begin
        drv_r <= win;
      end
    end
  end

  // A conflict in the same cycle as a clear wins: the sticky bit stays set and the count restarts at 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_sticky   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (conflict) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end

      if (err_clr) begin
        conflict_cnt <= CNT_W'(conflict);
      end else if (conflict && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gated_bus_n.sv
// tb/tb_gated_bus_n.sv - directed scoreboard bench for gated_bus_n (N=4, WIDTH=16, CNT_W=3).
module tb_gated_bus_n;

  logic        Clk;
  logic        Reset_n;
  logic [3:0]  gate;
  logic [63:0] din;
  logic        err_clr;
  logic [15:0] bus_q;
  logic        conflict;
  logic [15:0] bus_r;
  logic [1:0]  drv_r;
  logic        valid_r;
  logic        err_sticky;
  logic [2:0]  conflict_cnt;

`ifdef GATED_BUS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  gated_bus_n #(.WIDTH(16), .N(4), .CNT_W(3)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .gate         (gate),
    .din          (din),
    .err_clr      (err_clr),
    .bus_q        (bus_q),
    .conflict     (conflict),
    .bus_r        (bus_r),
    .drv_r        (drv_r),
    .valid_r      (valid_r),
    .err_sticky   (err_sticky),
    .conflict_cnt (conflict_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] bus_r;
    logic [1:0]  drv_r;
    logic        valid_r;
    logic        err_sticky;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  m_drv;
  logic        m_sticky;
  logic [2:0]  m_cnt;
  logic [15:0] m_keep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [15:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_reset();
    m_drv = '0; m_sticky = 1'b0; m_cnt = '0; m_keep = '0;
  endtask

  task automatic step(input logic [3:0] g, input logic [63:0] d, input logic clr);
    exp_t        e;
    int          w;
    logic        cf;
    logic [15:0] bq;
    gate = g; din = d; err_clr = clr;
    #1;
    w = 0;
    for (int i = 3; i >= 0; i--) if (g[i]) w = i;
    cf = ($countones(g) >= 2);
    bq = (g != 0) ? d[w*16 +: 16] : (HOLD ? m_keep : 16'h0);
    check("bus_q", bus_q, bq);
    check("conflict", conflict, cf);
    if (g != 0) begin
      m_drv  = w[1:0];
      m_keep = bq;
    end
    if (cf) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    if (clr) m_cnt = cf ? 3'd1 : 3'd0;
    else if (cf && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
    e.bus_r = bq; e.drv_r = m_drv; e.valid_r = (g != 0);
    e.err_sticky = m_sticky; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("bus_r", bus_r, e.bus_r);
      check("drv_r", drv_r, e.drv_r);
      check("valid_r", valid_r, e.valid_r);
      check("err_sticky", err_sticky, e.err_sticky);
      check("conflict_cnt", conflict_cnt, e.cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; gate = '0; din = '0; err_clr = 1'b0;
    model_reset();
    #3;
    check("rst_bus_q", bus_q, 16'h0);
    check("rst_bus_r", bus_r, 16'h0);
    check("rst_drv_r", drv_r, 2'd0);
    check("rst_valid_r", valid_r, 1'b0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_cnt", conflict_cnt, 3'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    step(4'b0100, mk(16'h0303, 16'h3000, 16'h0101, 16'h0000), 1'b0);
    step(4'b0001, mk(16'h0303, 16'h0202, 16'h0101, 16'hBEEF), 1'b0);
    step(4'b1010, mk(16'h3333, 16'h2222, 16'h1111, 16'h0000), 1'b0);

    for (int i = 0; i < 10; i++)
      step(4'b0110, mk(16'h0, 16'hCAFE, 16'h5A5A, 16'h0), 1'b0);

    step(4'b0001, mk(16'h0, 16'h0, 16'h0, 16'h1234), 1'b1);
    step(4'b1001, mk(16'h9999, 16'h0, 16'h0, 16'h7777), 1'b1);

    step(4'b0100, mk(16'h0, 16'h00A5, 16'h0, 16'h0), 1'b0);
    for (int i = 0; i < 3; i++)
      step(4'b0000, mk(16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC), 1'b0);

    step(4'b1000, mk(16'h8888, 16'h0, 16'h0, 16'h0), 1'b1);
    for (int i = 0; i < 5; i++)
      step(4'b1100, mk(16'hAAAA, 16'hBBBB, 16'h0, 16'h0), 1'b0);

    #2;
    Reset_n = 1'b0;
    gate = 4'b0100; din = mk(16'h0, 16'h4321, 16'h0, 16'h0);
    #1;
    check("mid_rst_bus_r", bus_r, 16'h0);
    check("mid_rst_drv_r", drv_r, 2'd0);
    check("mid_rst_valid_r", valid_r, 1'b0);
    check("mid_rst_err_sticky", err_sticky, 1'b0);
    check("mid_rst_cnt", conflict_cnt, 3'd0);
    check("mid_rst_bus_q_driven", bus_q, 16'h4321);
    gate = 4'b0000;
    #1;
    check("mid_rst_bus_q_idle", bus_q, 16'h0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    step(4'b0010, mk(16'h0, 16'h0, 16'h5678, 16'h0), 1'b0);
    step(4'b0000, mk(16'h0, 16'h0, 16'h0, 16'h0), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
